exp_lut_reader: RTL and testbench

- Front-end of the softmax exponent unit that issues read addresses to the 64-entry exp coefficient LUT.
- Accepts an fp16 operand x (normally x ≤ 0, after max-subtraction) over a valid/ready stream.
- Quantises |x| to a 6-bit segment index and drives the LUT address from a register.
- Captures the 32-bit LUT word one cycle later and emits it as two fp16 fields, with the segment fraction and status flags.
- The LUT itself is combinational and sits outside this block.

---
 rtl/exp_lut_reader_pkg.sv | 28 ++
 rtl/exp_idx_quant.sv | 71 +++++++
 rtl/exp_lut_reader.sv | 124 ++++++++++++
 tb/tb_exp_lut_reader.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/exp_lut_reader_pkg.sv
// Shared definitions for the softmax exp-LUT front-end.
// Holds the fp16 field layout, LUT geometry and the status-flag bit positions
// used by exp_idx_quant and exp_lut_reader.
package exp_lut_reader_pkg;

  // fp16 layout
  localparam int unsigned FP_W     = 16;
  localparam int unsigned SIGN_BIT = 15;
  localparam int unsigned EXP_MSB  = 14;
  localparam int unsigned EXP_LSB  = 10;
  localparam int unsigned EXP_W    = 5;
  localparam int unsigned MANT_W   = 10;
  localparam int unsigned EXP_BIAS = 15;
  localparam int unsigned EXP_MAX  = 31;

  // LUT geometry
  localparam int unsigned LUT_AW = 6;
  localparam int unsigned LUT_DW = 32;

  // Status flag bit positions
  localparam int unsigned FLAG_SAT = 0;
  localparam int unsigned FLAG_POS = 1;
  localparam int unsigned FLAG_NAN = 2;
  localparam int unsigned FLAG_W   = 3;

  typedef logic [FLAG_W-1:0] flags_t;

endpackage

// File: rtl/exp_idx_quant.sv
// Combinational fp16 -> LUT segment quantiser.
// Computes idx = floor(|x| * 2^SCALE_SH) and the next FRAC_W bits below it
// (truncated), plus saturation / positive / NaN-Inf flags.
// Ports:
//   x_i     fp16 operand
//   idx_o   segment index (0..63)
//   frac_o  sub-segment fraction, MSB-aligned
//   flags_o status flags at FLAG_SAT / FLAG_POS / FLAG_NAN
module exp_idx_quant
  import exp_lut_reader_pkg::*;
#(
  parameter int unsigned SCALE_SH = 3,
  parameter int unsigned FRAC_W   = 10
) (
  input  logic [FP_W-1:0]   x_i,
  output logic [LUT_AW-1:0] idx_o,
  output logic [FRAC_W-1:0] frac_o,
  output flags_t            flags_o
);

  // |x| = sig * 2^(e - FixFrac); FixFrac fraction bits sit below the binary point.
  localparam int unsigned FixFrac = EXP_BIAS + MANT_W;
  localparam int unsigned ProdW   = MANT_W + 1 + EXP_MAX + SCALE_SH + 1;
  localparam int unsigned WinW    = LUT_AW + FRAC_W;

  logic                sign;
  logic [EXP_W-1:0]    expo;
  logic [MANT_W-1:0]   mant;
  logic [MANT_W:0]     sig;
  logic [7:0]          shamt;
  logic [ProdW-1:0]    prod;
  logic [WinW-1:0]     win;
  logic                is_nan;
  logic                is_pos;
  logic                is_sat;

  assign sign  = x_i[SIGN_BIT];
  assign expo  = x_i[EXP_MSB:EXP_LSB];
  assign mant  = x_i[MANT_W-1:0];
  assign sig   = {expo != '0, mant};
  assign shamt = 8'(expo) + 8'(SCALE_SH);

  // sig << (e + SCALE_SH) keeps FixFrac fraction bits; the window picks the
  // LUT_AW integer bits and the top FRAC_W fraction bits.
  assign prod = ProdW'(sig) << shamt;
  assign win  = WinW'(prod >> (FixFrac - FRAC_W));

  assign is_nan = (expo == EXP_W'(EXP_MAX));
  assign is_pos = !is_nan && !sign && (x_i[SIGN_BIT-1:0] != '0);
  // e - bias + SCALE_SH >= LUT_AW means the integer part no longer fits
  assign is_sat = is_nan || (!is_pos && (shamt >= 8'(EXP_BIAS + LUT_AW)));

  always_comb begin
    idx_o  = '0;
    frac_o = '0;
    if (is_sat) begin
      idx_o  = '1;
      frac_o = '1;
    end else if (!is_pos && (expo != '0)) begin
      {idx_o, frac_o} = win;
    end
  end

  always_comb begin
    flags_o           = '0;
    flags_o[FLAG_SAT] = is_sat;
    flags_o[FLAG_POS] = is_pos;
    flags_o[FLAG_NAN] = is_nan;
  end

endmodule

// File: rtl/exp_lut_reader.sv
// Softmax exp-unit front-end: quantises an fp16 operand to a LUT segment,
// drives the registered LUT address and captures the LUT word one cycle later.
// Two-stage valid/ready pipeline (S1: address, S2: LUT word), latency 2,
// throughput 1/cycle.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   in_valid/in_ready     operand handshake, in_x fp16 operand
//   lut_addr/lut_data     registered LUT address, combinational LUT word
//   out_valid/out_ready   result handshake
//   out_hi/out_lo         upper / lower fp16 fields of the LUT word
//   out_frac              sub-segment fraction
//   out_sat/pos/nan       status flags
module exp_lut_reader
  import exp_lut_reader_pkg::*;
#(
  parameter int unsigned SCALE_SH = 3,
  parameter int unsigned FRAC_W   = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [FP_W-1:0]     in_x,
  output logic [LUT_AW-1:0]   lut_addr,
  input  logic [LUT_DW-1:0]   lut_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [LUT_DW/2-1:0] out_hi,
  output logic [LUT_DW/2-1:0] out_lo,
  output logic [FRAC_W-1:0]   out_frac,
  output logic                out_sat,
  output logic                out_pos,
  output logic                out_nan
);

  logic [LUT_AW-1:0] q_idx;
  logic [FRAC_W-1:0] q_frac;
  flags_t            q_flags;

  exp_idx_quant #(
    .SCALE_SH (SCALE_SH),
    .FRAC_W   (FRAC_W)
  ) u_quant (
    .x_i     (in_x),
    .idx_o   (q_idx),
    .frac_o  (q_frac),
    .flags_o (q_flags)
  );

  logic              s1_v_q, s1_v_d;
  logic [LUT_AW-1:0] s1_idx_q, s1_idx_d;
  logic [FRAC_W-1:0] s1_frac_q, s1_frac_d;
  flags_t            s1_flags_q, s1_flags_d;

  logic              s2_v_q, s2_v_d;
  logic [LUT_DW-1:0] s2_data_q, s2_data_d;
  logic [FRAC_W-1:0] s2_frac_q, s2_frac_d;
  flags_t            s2_flags_q, s2_flags_d;

  logic s2_adv;
  logic s1_adv;
  logic accept;

  assign s2_adv   = !s2_v_q || out_ready;
  assign s1_adv   = s1_v_q && s2_adv;
  assign in_ready = !s1_v_q || s2_adv;
  assign accept   = in_valid && in_ready;

  always_comb begin
    s1_idx_d   = s1_idx_q;
    s1_frac_d  = s1_frac_q;
    s1_flags_d = s1_flags_q;
    s2_data_d  = s2_data_q;
    s2_frac_d  = s2_frac_q;
    s2_flags_d = s2_flags_q;

    // S1 payload only changes on accept, so lut_addr holds while stalled or idle
    if (accept) begin
      s1_idx_d   = q_idx;
      s1_frac_d  = q_frac;
      s1_flags_d = q_flags;
    end
    s1_v_d = accept || (s1_v_q && !s1_adv);

    if (s1_adv) begin
      s2_data_d  = lut_data;
      s2_frac_d  = s1_frac_q;
      s2_flags_d = s1_flags_q;
    end
    s2_v_d = s1_adv || (s2_v_q && !out_ready);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_v_q     <= 1'b0;
      s1_idx_q   <= '0;
      s1_frac_q  <= '0;
      s1_flags_q <= '0;
      s2_v_q     <= 1'b0;
      s2_data_q  <= '0;
      s2_frac_q  <= '0;
      s2_flags_q <= '0;
    end else begin
      s1_v_q     <= s1_v_d;
      s1_idx_q   <= s1_idx_d;
      s1_frac_q  <= s1_frac_d;
      s1_flags_q <= s1_flags_d;
      s2_v_q     <= s2_v_d;
      s2_data_q  <= s2_data_d;
      s2_frac_q  <= s2_frac_d;
      s2_flags_q <= s2_flags_d;
    end
  end

  assign lut_addr  = s1_idx_q;
  assign out_valid = s2_v_q;
  assign out_hi    = s2_data_q[LUT_DW-1:LUT_DW/2];
  assign out_lo    = s2_data_q[LUT_DW/2-1:0];
  assign out_frac  = s2_frac_q;
  assign out_sat   = s2_flags_q[FLAG_SAT];
  assign out_pos   = s2_flags_q[FLAG_POS];
  assign out_nan   = s2_flags_q[FLAG_NAN];

endmodule

// File: tb/tb_exp_lut_reader.sv
// Self-checking bench for exp_lut_reader with a behavioural LUT and a
// real-arithmetic quantiser reference model.
module tb_exp_lut_reader;

  localparam int Sh    = 3;
  localparam int FracW = 10;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_x;
  logic [5:0]  lut_addr;
  logic [31:0] lut_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_hi;
  logic [15:0] out_lo;
  logic [FracW-1:0] out_frac;
  logic        out_sat;
  logic        out_pos;
  logic        out_nan;

  logic [31:0] lut_mem [64];

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct packed {
    logic [5:0]       idx;
    logic [FracW-1:0] frac;
    logic             sat;
    logic             pos;
    logic             nan;
  } q_t;

  exp_lut_reader #(
    .SCALE_SH (Sh),
    .FRAC_W   (FracW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .lut_addr  (lut_addr),
    .lut_data  (lut_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_hi    (out_hi),
    .out_lo    (out_lo),
    .out_frac  (out_frac),
    .out_sat   (out_sat),
    .out_pos   (out_pos),
    .out_nan   (out_nan)
  );

  assign lut_data = lut_mem[lut_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, want);
  endtask

  // |x| * 2^Sh evaluated with real arithmetic, then split into int/frac
  function automatic q_t ref_quant(input logic [15:0] x);
    q_t  r;
    real v;
    int  e;
    int  ip;
    r = '0;
    e = int'(x[14:10]);
    if (e == 31) begin
      r.nan = 1'b1; r.sat = 1'b1; r.idx = 6'd63; r.frac = '1;
    end else if (!x[15] && (x[14:0] != 15'd0)) begin
      r.pos = 1'b1;
    end else if (e != 0) begin
      v = real'(1024 + int'(x[9:0]));
      for (int i = 0; i < e; i++) v = v * 2.0;
      for (int i = 0; i < 25 - Sh; i++) v = v / 2.0;
      if (v >= 64.0) begin
        r.sat = 1'b1; r.idx = 6'd63; r.frac = '1;
      end else begin
        ip     = $rtoi(v);
        r.idx  = 6'(ip);
        r.frac = FracW'($rtoi((v - real'(ip)) * 1024.0));
      end
    end
    return r;
  endfunction

  function automatic logic [63:0] exp_word(input q_t r);
    return 64'({lut_mem[r.idx], r.frac, r.sat, r.pos, r.nan});
  endfunction

  function automatic logic [63:0] dut_word();
    return 64'({out_hi, out_lo, out_frac, out_sat, out_pos, out_nan});
  endfunction

  function automatic logic [15:0] rand_x();
    logic [15:0] specials [9];
    specials = '{16'h0000, 16'h8000, 16'h7C00, 16'hFC00, 16'h7E00,
                 16'h3C00, 16'hC900, 16'h0001, 16'h8001};
    case ($urandom % 4)
      0, 1:    return {1'b1, 5'($urandom_range(0, 20)), 10'($urandom)};
      2:       return 16'($urandom);
      default: return specials[$urandom % 9];
    endcase
  endfunction

  // One isolated operand with out_ready high: exact latency-2 check
  task automatic run_single(input string tag, input logic [15:0] x);
    q_t r;
    r = ref_quant(x);
    @(negedge clk);
    out_ready = 1'b1; in_x = x; in_valid = 1'b1;
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, "_addr"}, 64'(lut_addr), 64'(r.idx));
    check({tag, "_valid_n1"}, 64'(out_valid), 64'd0);
    @(negedge clk);
    check({tag, "_valid_n2"}, 64'(out_valid), 64'd1);
    check({tag, "_out"}, dut_word(), exp_word(r));
    @(negedge clk);
    check({tag, "_drained"}, 64'(out_valid), 64'd0);
    check({tag, "_addr_hold"}, 64'(lut_addr), 64'(r.idx));
  endtask

  // Streams n items against a FIFO scoreboard; directed mode uses bp_x and
  // holds out_ready low for the first `stall` cycles.
  task automatic run_stream(input string tag, input int n, input bit rnd, input int stall);
    logic [15:0] bp_x [4];
    q_t          expq [$];
    int          sent, got, cyc;
    bit          cur_v;
    logic [15:0] cur_x;
    bp_x  = '{16'h0000, 16'hB800, 16'hBC00, 16'hBE00};
    sent  = 0; got = 0; cyc = 0; cur_v = 1'b0; cur_x = '0;
    while (got < n && cyc < 60000) begin
      @(negedge clk);
      if (!cur_v && sent < n && (!rnd || ($urandom % 4 != 0))) begin
        cur_v = 1'b1;
        cur_x = rnd ? rand_x() : bp_x[sent];
      end
      in_valid  = cur_v;
      in_x      = cur_x;
      out_ready = rnd ? ($urandom % 4 != 0) : (cyc >= stall);
      #1;
      if (!rnd && cyc == 2) check({tag, "_in_ready_low"}, 64'(in_ready), 64'd0);
      if (!rnd && cyc == 3) begin
        check({tag, "_stall_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_stall_addr"}, 64'(lut_addr), 64'd4);
      end
      if (out_valid) begin
        if (expq.size() == 0) begin
          check({tag, "_spurious"}, 64'd1, 64'd0);
        end else begin
          if (rnd) begin
            if (dut_word() !== exp_word(expq[0])) check({tag, "_out"}, dut_word(), exp_word(expq[0]));
            else check({tag, "_out"}, dut_word(), exp_word(expq[0]));
          end else begin
            check({tag, "_out"}, dut_word(), exp_word(expq[0]));
          end
          if (out_ready) begin
            void'(expq.pop_front());
            got++;
          end
        end
      end
      if (in_valid && in_ready) begin
        expq.push_back(ref_quant(cur_x));
        sent++;
        cur_v = 1'b0;
      end
      cyc++;
    end
    check({tag, "_count"}, 64'(got), 64'(n));
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      lut_mem[i] = {16'(i * 16'h0123 + 16'h1000), 16'(16'hF000 - i * 16'h0211)};
    end
    lut_mem[0]  = 32'h3BC1_3C00;
    lut_mem[4]  = 32'h38B4_3B34;
    lut_mem[8]  = 32'h35B5_39CC;
    lut_mem[12] = 32'h32EC_3861;
    lut_mem[63] = 32'h0E0A_1AB9;

    reset = 1'b1; in_valid = 1'b0; in_x = '0; out_ready = 1'b1;
    #12;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_addr", 64'(lut_addr), 64'd0);
    check("rst_out", dut_word(), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    run_single("zero", 16'h0000);
    run_single("m1p0", 16'hBC00);
    run_single("m0p5", 16'hB800);
    run_single("m1p5", 16'hBE00);
    run_single("m0p625", 16'hB900);
    run_single("m10", 16'hC900);
    run_single("pinf", 16'h7C00);
    run_single("p1p0", 16'h3C00);
    run_single("nzero", 16'h8000);
    run_single("m0p7", 16'hB99A);

    run_stream("bp", 4, 1'b0, 5);

    // Two items in flight, then asynchronous reset mid-cycle
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_x = 16'hB800;
    @(negedge clk);
    in_x = 16'hBC00;
    @(negedge clk);
    in_valid = 1'b0;
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_addr", 64'(lut_addr), 64'd0);
    @(negedge clk);
    reset = 1'b0; out_ready = 1'b1;
    run_single("post_rst", 16'hBE00);

    run_stream("rnd", 10000, 1'b1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
